interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Memory-mapped 8-source interrupt controller sitting directly upstream of the CPU core. It synchronises asynchronous peripheral interrupt lines, latches them per source as edge- or level-triggered, masks them, and drives the CPU's 8-bit pending-interrupt input plus a single request line. The CPU configures it, acknowledges and claims interrupts over the same data bus it uses for memory (Dw* signals), so the block appears as a slave on that bus.

## Interface
Parameters:
- BASE_ADDR, 32'hFF20_0000, word-aligned base of the 16-byte register window
- NSRC, 8, number of sources (fixed at 8 for this revision)

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset; asynchronous, active-low
- iIrqSrc  in  8  raw interrupt lines, asynchronous to iCLK
- iDwReadEnable  in  1  CPU data-bus read strobe
- iDwWriteEnable  in  1  CPU data-bus write strobe
- iDwByteEnable  in  4  byte lanes of the access
- iDwAddress  in  32  byte address
- iDwWriteData  in  32  write data
- oDwReadData  out  32  read data; 0 when window not selected or no read
- oPendingInterrupt  out  8  rPending & rEnable, to the CPU's pending-interrupt input
- oIRQ  out  1  OR-reduction of oPendingInterrupt
- oClaimID  out  4  {valid, id[2:0]} of highest-priority active source

## Operation
- Select: iDwAddress[31:4] == BASE_ADDR[31:4]; register = iDwAddress[3:2]. Addresses [1:0] ignored.
- Registers (data in bits [7:0], upper bits read 0):
  - 0x0 PENDING: read rPending; write-1-to-clear, edge-mode bits only.
  - 0x4 ENABLE: R/W mask.
  - 0x8 MODE: R/W; bit=1 edge, 0 level.
  - 0xC CLAIM: read returns {28'b0, oClaimID}; first cycle of a read clears the claimed bit if edge mode. Writes ignored.
- Writes take effect at the clock edge only when iDwWriteEnable=1, select true and iDwByteEnable[0]=1; other lanes ignored.
- Synchroniser: two flops per source (s1, s2) plus history flop s3.
- Edge mode: s2 & ~s3 sets rPending[i]. Level mode: rPending[i] <= s2 every cycle; W1C and claim have no effect.
- Priority: lowest index wins. valid=0, id=0 when no enabled pending bit.
- Claim side-effect edge detection: register rRdClaimQ = (read & select & reg==0xC); side-effect applies only when current is 1 and rRdClaimQ is 0. A read held for multiple cycles (multicycle CPU) claims exactly once.
- Writing MODE from level to edge leaves the current pending value; edge to level replaced by s2 next cycle.

## Timing
- Reset (iRST=0, async): rPending, rEnable, rMode, s1..s3, rRdClaimQ = 0; oPendingInterrupt=0, oIRQ=0, oClaimID=0, oDwReadData=0.
- Source rise sampled at edge N into s1 -> s2 at N+1 -> rPending set at N+2; oIRQ visible after N+2 (combinational from registers).
- oDwReadData combinational from registers in the access cycle (zero wait states, same as memory).
- oPendingInterrupt, oIRQ, oClaimID combinational from registered state only; no input-to-output path.
- Simultaneous set and clear (W1C or claim) on the same bit in the same cycle: set wins.
- W1C/claim on one bit never affects other bits.
- ENABLE masks only outputs; masked sources still latch into rPending.
- Reset asserted mid-access: all state cleared immediately; access lost, no side effect after release.
- Read and write strobes both high: write performed, read data still returned.

## Test plan
- Reset: drive iIrqSrc=8'hFF, iRST=0 -> all outputs 0; release, MODE=0, ENABLE=0 -> PENDING reads 0xFF at N+2, oIRQ=0.
- Edge latch and claim: MODE=0xFF, ENABLE=0x0C, pulse src2 and src3 -> oClaimID=4'b1010; CLAIM read returns 0xA, next oClaimID=0xB; second read 0xB; third read 0x0, oIRQ=0.
- Held read: CLAIM read strobe high 3 cycles with src1,src4 pending (edge, enabled) -> only bit1 cleared, PENDING=0x10.
- Set-wins collision: W1C 0x01 on the same edge src0 edge sets pending -> PENDING still 0x01.
- Level mode: MODE=0, ENABLE=0x80, hold src7 high -> oIRQ=1, W1C 0x80 and CLAIM ignored; drop src7 -> oIRQ=0 two cycles later.
- Byte lane/address: write ENABLE with iDwByteEnable=4'b1110 -> ENABLE unchanged; access at BASE_ADDR+0x10 -> oDwReadData=0, no register change.

Source files
------------

// File: rtl/interrupt_controller.sv
// 8-source interrupt controller: synchronises raw lines, latches them per source
// (edge or level), masks them and presents pending/claim state as a bus slave.
module interrupt_controller #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
  parameter int unsigned NSRC      = 8
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [NSRC-1:0] iIrqSrc,
  input  logic            iDwReadEnable,
  input  logic            iDwWriteEnable,
  input  logic [3:0]      iDwByteEnable,
  input  logic [31:0]     iDwAddress,
  input  logic [31:0]     iDwWriteData,
  output logic [31:0]     oDwReadData,
  output logic [NSRC-1:0] oPendingInterrupt,
  output logic            oIRQ,
  output logic [3:0]      oClaimID
);

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_MODE    = 2'd2,
    REG_CLAIM   = 2'd3
  } reg_sel_e;

  logic [NSRC-1:0] r_s1, r_s2, r_s3;
  logic [NSRC-1:0] r_pending, r_enable, r_mode;
  logic            r_rd_claim_q;

  logic            w_sel;
  reg_sel_e        w_reg;
  logic            w_wr;
  logic            w_rd_claim;
  logic [NSRC-1:0] w_active;
  logic            w_claim_valid;
  logic [2:0]      w_claim_id;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pending_nxt;
  logic            w_unused;

  assign w_sel      = (iDwAddress[31:4] == BASE_ADDR[31:4]);
  assign w_reg      = reg_sel_e'(iDwAddress[3:2]);
  assign w_wr       = iDwWriteEnable & w_sel & iDwByteEnable[0];
  assign w_rd_claim = iDwReadEnable & w_sel & (w_reg == REG_CLAIM);
  assign w_unused   = ^{iDwAddress[1:0], iDwByteEnable[3:1], iDwWriteData[31:NSRC]};

  assign w_active          = r_pending & r_enable;
  assign oPendingInterrupt = w_active;
  assign oIRQ              = |w_active;
  assign oClaimID          = {w_claim_valid, w_claim_id};

  // Descending scan so the lowest active index is the last (winning) assignment.
  always_comb begin
    w_claim_valid = 1'b0;
    w_claim_id    = '0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (w_active[i-1]) begin
        w_claim_valid = 1'b1;
        w_claim_id    = 3'(i - 1);
      end
    end
  end

  // Clears from W1C and from the first cycle of a CLAIM read; only edge bits honour them,
  // and a same-cycle edge set overrides the clear.
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_reg == REG_PENDING))
      w_clr = iDwWriteData[NSRC-1:0];
    if (w_rd_claim && !r_rd_claim_q && w_claim_valid)
      w_clr[w_claim_id] = 1'b1;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (r_mode[i])
        w_pending_nxt[i] = (r_s2[i] & ~r_s3[i]) | (r_pending[i] & ~w_clr[i]);
      else
        w_pending_nxt[i] = r_s2[i];
    end
  end

  always_comb begin
    oDwReadData = '0;
    if (iDwReadEnable && w_sel) begin
      unique case (w_reg)
        REG_PENDING: oDwReadData = 32'(r_pending);
        REG_ENABLE:  oDwReadData = 32'(r_enable);
        REG_MODE:    oDwReadData = 32'(r_mode);
        REG_CLAIM:   oDwReadData = 32'(oClaimID);
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_s3         <= '0;
      r_pending    <= '0;
      r_enable     <= '0;
      r_mode       <= '0;
      r_rd_claim_q <= 1'b0;
    end else begin
      r_s1         <= iIrqSrc;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_pending    <= w_pending_nxt;
      r_rd_claim_q <= w_rd_claim;
      if (w_wr && (w_reg == REG_ENABLE)) r_enable <= iDwWriteData[NSRC-1:0];
      if (w_wr && (w_reg == REG_MODE))   r_mode   <= iDwWriteData[NSRC-1:0];
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios followed by
// random bus/source traffic, all checked against a cycle-level reference model.
module tb_interrupt_controller;

  localparam logic [31:0] BASE = 32'hFF20_0000;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [7:0]  iIrqSrc;
  logic        iDwReadEnable, iDwWriteEnable;
  logic [3:0]  iDwByteEnable;
  logic [31:0] iDwAddress, iDwWriteData;
  logic [31:0] oDwReadData;
  logic [7:0]  oPendingInterrupt;
  logic        oIRQ;
  logic [3:0]  oClaimID;

  interrupt_controller #(.BASE_ADDR(BASE), .NSRC(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iIrqSrc(iIrqSrc),
    .iDwReadEnable(iDwReadEnable), .iDwWriteEnable(iDwWriteEnable),
    .iDwByteEnable(iDwByteEnable), .iDwAddress(iDwAddress), .iDwWriteData(iDwWriteData),
    .oDwReadData(oDwReadData), .oPendingInterrupt(oPendingInterrupt),
    .oIRQ(oIRQ), .oClaimID(oClaimID)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: the last three samples of each source line, plus register contents.
  bit [7:0] hist [3];
  bit [7:0] m_pend, m_en, m_mode;
  bit       m_prev_claim_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [3:0] m_claim();
    bit [7:0] act = m_pend & m_en;
    for (int i = 0; i < 8; i++)
      if (act[i]) return {1'b1, 3'(i)};
    return 4'h0;
  endfunction

  function automatic bit m_sel();
    return iDwAddress[31:4] == BASE[31:4];
  endfunction

  function automatic bit [31:0] m_read();
    if (!iDwReadEnable || !m_sel()) return 32'h0;
    case (iDwAddress[3:2])
      2'd0:    return {24'h0, m_pend};
      2'd1:    return {24'h0, m_en};
      2'd2:    return {24'h0, m_mode};
      default: return {28'h0, m_claim()};
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) hist[i] = 8'h0;
    m_pend = 0; m_en = 0; m_mode = 0; m_prev_claim_rd = 0;
  endtask

  // One clock: check combinational read data, advance model, compare registered outputs.
  task automatic step();
    bit [7:0] clr, np, nen, nmode;
    bit [3:0] c;
    bit wr, crd;
    #2;
    check("rdata", oDwReadData, m_read());
    wr  = iDwWriteEnable && m_sel() && iDwByteEnable[0];
    crd = iDwReadEnable && m_sel() && (iDwAddress[3:2] == 2'd3);
    clr = 0;
    if (wr && iDwAddress[3:2] == 2'd0) clr = iDwWriteData[7:0];
    c = m_claim();
    if (crd && !m_prev_claim_rd && c[3]) clr[c[2:0]] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (m_mode[i]) np[i] = (hist[1][i] && !hist[2][i]) || (m_pend[i] && !clr[i]);
      else           np[i] = hist[1][i];
    end
    nen   = (wr && iDwAddress[3:2] == 2'd1) ? iDwWriteData[7:0] : m_en;
    nmode = (wr && iDwAddress[3:2] == 2'd2) ? iDwWriteData[7:0] : m_mode;
    @(posedge iCLK);
    #1;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = iIrqSrc;
    m_pend = np; m_en = nen; m_mode = nmode; m_prev_claim_rd = crd;
    check("pending_out", oPendingInterrupt, m_pend & m_en);
    check("irq", oIRQ, |(m_pend & m_en));
    check("claim_id", oClaimID, m_claim());
  endtask

  task automatic idle(input int n);
    iDwReadEnable = 0; iDwWriteEnable = 0; iDwByteEnable = 4'hF;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] data);
    iDwAddress = BASE + off; iDwWriteData = data;
    iDwWriteEnable = 1; iDwReadEnable = 0; iDwByteEnable = 4'hF;
    step();
    iDwWriteEnable = 0;
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
    iDwAddress = BASE + off; iDwReadEnable = 1; iDwWriteEnable = 0;
    #1 check(tag, oDwReadData, exp);
    step();
    iDwReadEnable = 0;
  endtask

  initial begin
    m_reset();
    iRST = 0; iIrqSrc = 8'hFF;
    iDwReadEnable = 0; iDwWriteEnable = 0; iDwByteEnable = 4'hF;
    iDwAddress = BASE; iDwWriteData = 0;
    #12;
    check("rst_pending", oPendingInterrupt, 8'h00);
    check("rst_irq", oIRQ, 1'b0);
    check("rst_claim", oClaimID, 4'h0);
    iDwReadEnable = 1;
    #1 check("rst_rdata", oDwReadData, 32'h0);
    iDwReadEnable = 0;
    @(posedge iCLK); #1;
    iRST = 1;

    // Level mode, all sources high: PENDING fills two edges after sampling.
    iDwAddress = BASE; iDwReadEnable = 1;
    step(); step();
    #1 check("pend_before_n2", oDwReadData, 32'h00);
    step();
    #1 check("pend_at_n2", oDwReadData, 32'hFF);
    check("irq_masked", oIRQ, 1'b0);
    idle(1);

    // Edge latch and sequential claims.
    iIrqSrc = 8'h00; idle(3);
    wr_reg(32'h8, 32'hFF);
    wr_reg(32'h4, 32'h0C);
    iIrqSrc = 8'h0C; idle(1); iIrqSrc = 8'h00; idle(3);
    check("claim_first", oClaimID, 4'hA);
    rd_reg("claim_rd1", 32'hC, 32'hA);
    check("claim_next", oClaimID, 4'hB);
    idle(1);
    rd_reg("claim_rd2", 32'hC, 32'hB);
    idle(1);
    rd_reg("claim_rd3", 32'hC, 32'h0);
    check("irq_drained", oIRQ, 1'b0);

    // Held CLAIM read claims only once.
    wr_reg(32'h4, 32'h12);
    iIrqSrc = 8'h12; idle(1); iIrqSrc = 8'h00; idle(3);
    iDwAddress = BASE + 32'hC; iDwReadEnable = 1;
    step(); step(); step();
    iDwReadEnable = 0;
    idle(1);
    rd_reg("held_claim", 32'h0, 32'h10);

    // Edge set collides with W1C on the same bit: set wins.
    wr_reg(32'h0, 32'h10);
    iIrqSrc = 8'h01; idle(2);
    wr_reg(32'h0, 32'h01);
    iIrqSrc = 8'h00;
    rd_reg("set_wins", 32'h0, 32'h01);

    // Level mode ignores W1C and claim.
    wr_reg(32'h0, 32'hFF);
    wr_reg(32'h8, 32'h00);
    wr_reg(32'h4, 32'h80);
    iIrqSrc = 8'h80; idle(3);
    check("level_irq", oIRQ, 1'b1);
    wr_reg(32'h0, 32'h80);
    rd_reg("level_claim", 32'hC, 32'hF);
    check("level_irq_kept", oIRQ, 1'b1);
    iIrqSrc = 8'h00; idle(2);
    check("level_drop_n1", oIRQ, 1'b1);
    idle(1);
    check("level_drop_n2", oIRQ, 1'b0);

    // Byte lane, window boundary, simultaneous read/write.
    iDwAddress = BASE + 32'h4; iDwWriteData = 32'hFF; iDwByteEnable = 4'b1110;
    iDwWriteEnable = 1; step(); idle(0); iDwWriteEnable = 0;
    rd_reg("lane_ignored", 32'h4, 32'h80);
    iDwAddress = BASE + 32'h14; iDwWriteData = 32'hFF; iDwByteEnable = 4'hF;
    iDwReadEnable = 1; iDwWriteEnable = 1;
    #1 check("outside_rdata", oDwReadData, 32'h0);
    step(); iDwWriteEnable = 0; iDwReadEnable = 0;
    rd_reg("outside_nowrite", 32'h4, 32'h80);
    iDwAddress = BASE + 32'h4; iDwWriteData = 32'h33;
    iDwReadEnable = 1; iDwWriteEnable = 1;
    #1 check("rw_old_data", oDwReadData, 32'h80);
    step(); iDwWriteEnable = 0; iDwReadEnable = 0;
    rd_reg("rw_new_data", 32'h4, 32'h33);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) iIrqSrc = 8'($urandom);
      iDwReadEnable  = ($urandom_range(0, 2) != 0);
      iDwWriteEnable = ($urandom_range(0, 3) == 0);
      iDwByteEnable  = 4'($urandom);
      iDwAddress     = ($urandom_range(0, 9) == 0) ? BASE + 32'h10 + 32'($urandom_range(0, 15))
                                                   : BASE + 32'($urandom_range(0, 15));
      iDwWriteData   = $urandom;
      step();
    end

    // Reset asserted mid-access clears everything at once.
    wr_reg(32'h4, 32'hFF);
    iDwAddress = BASE + 32'h8; iDwWriteData = 32'hFF; iDwWriteEnable = 1;
    #2 iRST = 0;
    #1;
    m_reset();
    check("midrst_pending", oPendingInterrupt, 8'h00);
    check("midrst_claim", oClaimID, 4'h0);
    iDwWriteEnable = 0; iDwReadEnable = 0; iIrqSrc = 8'h00;
    @(posedge iCLK); #1;
    iRST = 1;
    rd_reg("midrst_mode", 32'h8, 32'h00);
    rd_reg("midrst_enable", 32'h4, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
